jtframe_objscan: RTL and testbench



---
 rtl/jtframe_objscan_if.sv | 28 ++
 rtl/jtframe_objscan.sv | 143 ++++++++++++++
 tb/tb_jtframe_objscan.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_objscan_if.sv
// rtl/jtframe_objscan_if.sv - object RAM and draw-command bus of the sprite-table scanner
interface jtframe_objscan_if #(
    parameter int OBJW = 7,
    parameter int CW   = 12,
    parameter int PW   = 8
);
    logic [OBJW+1:0] ram_addr;
    logic [15:0]     ram_dout;
    logic            draw;
    logic            busy;
    logic [CW-1:0]   code;
    logic [8:0]      xpos;
    logic [3:0]      ysub;
    logic            hflip;
    logic            vflip;
    logic [PW-5:0]   pal;
    logic            done;

    modport master (
        output ram_addr, draw, code, xpos, ysub, hflip, vflip, pal, done,
        input  ram_dout, busy
    );

    modport slave (
        input  ram_addr, draw, code, xpos, ysub, hflip, vflip, pal, done,
        output ram_dout, busy
    );
endinterface

// File: rtl/jtframe_objscan.sv
// rtl/jtframe_objscan.sv - per-line sprite table scanner issuing draw commands
module jtframe_objscan #(
    parameter int OBJW   = 7,
    parameter int CW     = 12,
    parameter int PW     = 8,
    parameter int MAXOBJ = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hs,
    input  logic [8:0]          vrender,
    jtframe_objscan_if.master   bus
);
    localparam int CNTW = $clog2(MAXOBJ + 1);

    typedef enum logic [3:0] {
        IDLE, START, YCHK, RD1, RD2, RD3, WAIT, ISSUE, HOLD
    } state_t;

    state_t          st, st_nxt;
    logic            hs_l, hs_pend, hs_edge, restart;
    logic [8:0]      vrender_l, ydiff;
    logic            visible, last, fin;
    logic [OBJW-1:0] obj, obj_inc;
    logic [CNTW-1:0] cnt;
    logic [8:0]      xpos_s;
    logic [CW-1:0]   code_s;
    logic [3:0]      ysub_s;
    logic            dout_unused;

    // Not every RAM data bit is meaningful in every word
    assign dout_unused = ^bus.ram_dout;

    // A new line request is held pending until it can restart the scan without cutting a draw pulse
    assign hs_edge = hs & ~hs_l;
    assign restart = (hs_edge | hs_pend) & ~bus.draw;
    assign ydiff   = vrender_l - bus.ram_dout[8:0];
    assign visible = ydiff[8:4] == 5'd0;
    assign last    = &obj;
    assign obj_inc = obj + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_nxt;
    end

    // Next-state logic; w0 data is only consumed in YCHK, one settle cycle after its address
    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:  st_nxt = IDLE;
            START: st_nxt = YCHK;
            YCHK:  st_nxt = visible ? RD1 : (last ? IDLE : HOLD);
            RD1:   st_nxt = RD2;
            RD2:   st_nxt = RD3;
            RD3:   st_nxt = bus.busy ? WAIT : ISSUE;
            WAIT:  st_nxt = bus.busy ? WAIT : ISSUE;
            ISSUE: st_nxt = HOLD;
            HOLD:  st_nxt = fin ? IDLE : YCHK;
            default: st_nxt = IDLE;
        endcase
        if (restart) st_nxt = START;
    end

    // hs edge detection and pending-request flag
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_l    <= 1'b0;
            hs_pend <= 1'b0;
        end else begin
            hs_l    <= hs;
            hs_pend <= (hs_pend | hs_edge) & (st_nxt != START);
        end
    end

    // Datapath: RAM addressing, staging and command outputs (outputs move only when leaving ISSUE)
    always_ff @(posedge clk) begin
        if (rst) begin
            obj          <= '0;
            cnt          <= '0;
            fin          <= 1'b0;
            vrender_l    <= 9'd0;
            xpos_s       <= 9'd0;
            code_s       <= '0;
            ysub_s       <= 4'd0;
            bus.ram_addr <= '0;
            bus.draw     <= 1'b0;
            bus.done     <= 1'b1;
            bus.code     <= '0;
            bus.xpos     <= 9'd0;
            bus.ysub     <= 4'd0;
            bus.hflip    <= 1'b0;
            bus.vflip    <= 1'b0;
            bus.pal      <= '0;
        end else begin
            bus.draw <= 1'b0;
            if (st_nxt == START) begin
                obj          <= '0;
                bus.ram_addr <= '0;
            end else begin
                case (st)
                    START: begin
                        vrender_l <= vrender;
                        cnt       <= '0;
                        fin       <= 1'b0;
                        bus.done  <= 1'b0;
                    end
                    YCHK: begin
                        ysub_s <= ydiff[3:0];
                        if (visible) begin
                            bus.ram_addr <= {obj, 2'd1};
                        end else begin
                            obj          <= obj_inc;
                            bus.ram_addr <= {obj_inc, 2'd0};
                        end
                    end
                    RD1: bus.ram_addr <= {obj, 2'd2};
                    RD2: begin
                        xpos_s       <= bus.ram_dout[8:0];
                        bus.ram_addr <= {obj, 2'd3};
                    end
                    RD3: code_s <= bus.ram_dout[CW-1:0];
                    ISSUE: begin
                        bus.draw     <= 1'b1;
                        bus.code     <= code_s;
                        bus.xpos     <= xpos_s;
                        bus.ysub     <= ysub_s;
                        bus.hflip    <= bus.ram_dout[15];
                        bus.vflip    <= bus.ram_dout[14];
                        bus.pal      <= bus.ram_dout[PW-5:0];
                        cnt          <= cnt + 1'b1;
                        fin          <= last | (cnt == CNTW'(MAXOBJ - 1));
                        obj          <= obj_inc;
                        bus.ram_addr <= {obj_inc, 2'd0};
                    end
                    default: ;
                endcase
            end
            if (st != IDLE && st_nxt == IDLE) bus.done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_jtframe_objscan.sv
// tb/tb_jtframe_objscan.sv - scoreboard bench for jtframe_objscan
module tb_jtframe_objscan;
    logic       clk = 1'b0;
    logic       rst;
    logic       hs;
    logic [8:0] vrender;

    always #5 clk = ~clk;

    jtframe_objscan_if #(.OBJW(7), .CW(12), .PW(8)) bus();

    jtframe_objscan #(.OBJW(7), .CW(12), .PW(8), .MAXOBJ(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .hs      (hs),
        .vrender (vrender),
        .bus     (bus)
    );

    typedef struct packed {
        logic [11:0] code;
        logic [8:0]  xpos;
        logic [3:0]  ysub;
        logic        hflip;
        logic        vflip;
        logic [3:0]  pal;
    } cmd_t;

    cmd_t        exp_q[$];
    cmd_t        act, expv, last_cmd;
    logic [15:0] mem [0:511];
    int          n_chk = 0;
    int          n_fail = 0;
    int          busy_len = 0;
    int          bcnt = 0;
    int          cyc = 0;
    int          draws = 0;
    int          last_draw_cyc = -1;
    bit          gap_chk = 1'b0;
    logic        prev_draw = 1'b0;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    // Synchronous-read object RAM
    always @(posedge clk) bus.ram_dout <= mem[bus.ram_addr];

    // Drawer model: busy for busy_len cycles starting the cycle after draw
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst)           bcnt <= 0;
        else if (bus.draw) bcnt <= busy_len;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign bus.busy = (bcnt != 0);

    // Monitor: pops the scoreboard on each draw, checks handshake rules and output stability
    always @(negedge clk) begin
        if (!rst) begin
            act = {bus.code, bus.xpos, bus.ysub, bus.hflip, bus.vflip, bus.pal};
            if (bus.draw) begin
                draws++;
                chk("draw_consecutive", 32'(prev_draw), 32'd0);
                chk("draw_while_busy", 32'(bus.busy), 32'd0);
                if (gap_chk && last_draw_cyc >= 0)
                    chk("draw_gap_ge_41", 32'(cyc - last_draw_cyc >= 41), 32'd1);
                last_draw_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("draw_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    expv = exp_q.pop_front();
                    chk("code",  32'(act.code),  32'(expv.code));
                    chk("xpos",  32'(act.xpos),  32'(expv.xpos));
                    chk("ysub",  32'(act.ysub),  32'(expv.ysub));
                    chk("hflip", 32'(act.hflip), 32'(expv.hflip));
                    chk("vflip", 32'(act.vflip), 32'(expv.vflip));
                    chk("pal",   32'(act.pal),   32'(expv.pal));
                end
                last_cmd = act;
            end else if (bus.busy) begin
                chk("outputs_stable", 32'(act), 32'(last_cmd));
            end
            prev_draw = bus.draw;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) begin
            mem[4*i]   = 16'h0100;
            mem[4*i+1] = 16'h0000;
            mem[4*i+2] = 16'h0000;
            mem[4*i+3] = 16'h0000;
        end
    endtask

    task automatic set_obj(input int i, input logic [8:0] y, input logic [8:0] x,
                           input logic [11:0] c, input logic [15:0] w3);
        mem[4*i]   = {7'd0, y};
        mem[4*i+1] = {7'd0, x};
        mem[4*i+2] = {4'd0, c};
        mem[4*i+3] = w3;
    endtask

    task automatic push_exp(input logic [11:0] c, input logic [8:0] x, input logic [3:0] ys,
                            input logic hf, input logic vf, input logic [3:0] p);
        cmd_t e;
        e = {c, x, ys, hf, vf, p};
        exp_q.push_back(e);
    endtask

    task automatic pulse_hs();
        hs = 1'b1;
        tick(2);
        hs = 1'b0;
        tick(1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!bus.done && n < budget) begin
            tick(1);
            n++;
        end
        chk({name, "_done"}, 32'(bus.done), 32'd1);
    endtask

    task automatic run_scan(input string name, input int budget, input int ndraw);
        int n;
        draws = 0;
        pulse_hs();
        n = 0;
        while (bus.done && n < 10) begin
            tick(1);
            n++;
        end
        chk({name, "_started"}, 32'(bus.done), 32'd0);
        wait_done(name, budget);
        tick(3);
        chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_draws"}, 32'(draws), 32'(ndraw));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        hs = 1'b0;
        vrender = 9'd0;
        clear_mem();
        tick(3);
        rst = 1'b0;
        tick(1);

        chk("rst_draw", 32'(bus.draw), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd1);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_code", 32'(bus.code), 32'd0);
        chk("rst_xpos", 32'(bus.xpos), 32'd0);
        chk("rst_pal", 32'(bus.pal), 32'd0);
        tick(10);
        chk("idle_done", 32'(bus.done), 32'd1);
        chk("idle_ram_addr", 32'(bus.ram_addr), 32'd0);

        // Single visible object
        clear_mem();
        set_obj(5, 9'h040, 9'h123, 12'hABC, 16'h8003);
        vrender = 9'h045;
        push_exp(12'hABC, 9'h123, 4'h5, 1'b1, 1'b0, 4'h3);
        run_scan("single", 300, 1);

        // Y wrap-around: one visible across 511->0, one just below the line
        clear_mem();
        set_obj(10, 9'h1F8, 9'h1FF, 12'h001, 16'h4005);
        set_obj(11, 9'h004, 9'h010, 12'h222, 16'h8001);
        vrender = 9'h003;
        push_exp(12'h001, 9'h1FF, 4'hB, 1'b0, 1'b1, 4'h5);
        run_scan("wrap", 300, 1);

        // Drawer busy for 40 cycles after each draw
        clear_mem();
        set_obj(2,   9'h07F, 9'h011, 12'h321, 16'h0002);
        set_obj(50,  9'h080, 9'h0F0, 12'h654, 16'hC00E);
        set_obj(127, 9'h071, 9'h100, 12'hFED, 16'h8009);
        vrender = 9'h080;
        busy_len = 40;
        gap_chk = 1'b1;
        last_draw_cyc = -1;
        push_exp(12'h321, 9'h011, 4'h1, 1'b0, 1'b0, 4'h2);
        push_exp(12'h654, 9'h0F0, 4'h0, 1'b1, 1'b1, 4'hE);
        push_exp(12'hFED, 9'h100, 4'hF, 1'b1, 1'b0, 4'h9);
        run_scan("busy", 700, 3);
        tick(45);
        gap_chk = 1'b0;

        // Every object visible: only MAXOBJ draws
        clear_mem();
        busy_len = 3;
        vrender = 9'h010;
        for (int i = 0; i < 128; i++) begin
            logic [15:0] w3;
            logic [3:0]  lo;
            lo = 4'(i);
            w3 = {lo[0], lo[1], 10'd0, lo};
            set_obj(i, 9'(16 - (i & 15)), 9'(3 * i), 12'(12'h100 + i), w3);
            if (i < 32) push_exp(12'(12'h100 + i), 9'(3 * i), lo, lo[0], lo[1], lo);
        end
        run_scan("maxobj", 500, 32);
        tick(5);
        busy_len = 0;

        // hs mid-scan restarts from object 0 with the new line
        clear_mem();
        set_obj(0,   9'h11E, 9'h0AA, 12'h555, 16'hC00F);
        set_obj(100, 9'h050, 9'h022, 12'h777, 16'h0000);
        vrender = 9'h050;
        draws = 0;
        pulse_hs();
        tick(30);
        chk("abort_midscan", 32'(bus.done), 32'd0);
        vrender = 9'h120;
        push_exp(12'h555, 9'h0AA, 4'h2, 1'b1, 1'b1, 4'hF);
        pulse_hs();
        wait_done("abort", 400);
        tick(3);
        chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("abort_draws", 32'(draws), 32'd1);

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
